// File: rtl/key_conditioner.sv
// Synchronizes and debounces the three active-low command KEYs into clean levels and press pulses,
// and synchronizes the slide-switch bus for the register unit.
module key_conditioner #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 19
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       LoadA_n,
    input  logic       LoadB_n,
    input  logic       Execute_n,
    input  logic [7:0] SW,
    output logic       LoadA,
    output logic       LoadB,
    output logic       Execute,
    output logic       LoadA_P,
    output logic       LoadB_P,
    output logic       Execute_P,
    output logic [7:0] Din
);

    localparam int              NCH      = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [NCH-1:0] key_pressed_raw;
    logic [NCH-1:0] level;
    logic [NCH-1:0] pulse;

    // Channel order: 0 = LoadA, 1 = LoadB, 2 = Execute; inverted so 1 means pressed.
    assign key_pressed_raw = ~{Execute_n, LoadB_n, LoadA_n};

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic             s1_reg;
            logic             s2_reg;
            logic             st_reg;
            logic             st_next;
            logic             pulse_reg;
            logic             pulse_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            // The counter only runs while the synchronized key disagrees with the debounced state.
            always_comb begin
                st_next    = st_reg;
                pulse_next = 1'b0;
                cnt_next   = '0;
                if (s2_reg != st_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        st_next    = s2_reg;
                        pulse_next = s2_reg;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge Clk) begin
                if (!Reset) begin
                    s1_reg    <= 1'b0;
                    s2_reg    <= 1'b0;
                    st_reg    <= 1'b0;
                    pulse_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    s1_reg    <= key_pressed_raw[gi];
                    s2_reg    <= s1_reg;
                    st_reg    <= st_next;
                    pulse_reg <= pulse_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign level[gi] = st_reg;
            assign pulse[gi] = pulse_reg;
        end
    endgenerate

    // Switches are only synchronized; they are not debounced.
    logic [7:0] sw_s1_reg;
    logic [7:0] sw_s2_reg;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sw_s1_reg <= '0;
            sw_s2_reg <= '0;
        end else begin
            sw_s1_reg <= SW;
            sw_s2_reg <= sw_s1_reg;
        end
    end

    assign LoadA     = level[0];
    assign LoadB     = level[1];
    assign Execute   = level[2];
    assign LoadA_P   = pulse[0];
    assign LoadB_P   = pulse[1];
    assign Execute_P = pulse[2];
    assign Din       = sw_s2_reg;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with a 4-cycle debounce: fixed vector table, corner-case sequences,
// and a randomized run against a run-length reference model.
module tb_key_conditioner;

    localparam int DB = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] keys_n;
    logic [7:0] SW;
    wire        LoadA_n;
    wire        LoadB_n;
    wire        Execute_n;
    logic       LoadA, LoadB, Execute;
    logic       LoadA_P, LoadB_P, Execute_P;
    logic [7:0] Din;

    assign {Execute_n, LoadB_n, LoadA_n} = keys_n;

    key_conditioner #(.DB_CYCLES(DB), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .LoadA_n(LoadA_n), .LoadB_n(LoadB_n), .Execute_n(Execute_n),
        .SW(SW),
        .LoadA(LoadA), .LoadB(LoadB), .Execute(Execute),
        .LoadA_P(LoadA_P), .LoadB_P(LoadB_P), .Execute_P(Execute_P),
        .Din(Din)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a 2-deep delay line per signal and, per key, the length of the current
    // run of edges on which the synchronized key disagrees with the debounced level.
    logic [2:0] key_pipe[$];
    logic [7:0] sw_pipe[$];
    logic [2:0] m_st  = '0;
    logic [2:0] m_pls = '0;
    logic [7:0] m_din = '0;
    int         m_run[3];

    task automatic model_step();
        logic [2:0] s2;
        if (!Reset) begin
            key_pipe = '{3'b000, 3'b000};
            sw_pipe  = '{8'h00, 8'h00};
            m_st = '0; m_pls = '0; m_din = '0;
            m_run = '{0, 0, 0};
        end else begin
            s2    = key_pipe[0];
            m_pls = '0;
            for (int c = 0; c < 3; c++) begin
                if (s2[c] != m_st[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB) begin
                        m_st[c]  = s2[c];
                        m_pls[c] = s2[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            void'(key_pipe.pop_front());
            key_pipe.push_back(~keys_n);
            void'(sw_pipe.pop_front());
            sw_pipe.push_back(SW);
            m_din = sw_pipe[0];
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        chk("model_level", {5'd0, Execute, LoadB, LoadA}, {5'd0, m_st});
        chk("model_pulse", {5'd0, Execute_P, LoadB_P, LoadA_P}, {5'd0, m_pls});
        chk("model_din", Din, m_din);
    endtask

    task automatic idle(input int n);
        keys_n = 3'b111;
        Reset  = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] kn;
        logic [7:0] sw;
        logic [2:0] lvl;
        logic [2:0] pls;
        logic [7:0] din;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [2:0] kn, input logic [7:0] sw,
                       input logic [2:0] lvl, input logic [2:0] pls, input logic [7:0] din);
        vec_t v;
        v.rst = r; v.kn = kn; v.sw = sw; v.lvl = lvl; v.pls = pls; v.din = din;
        vq.push_back(v);
    endtask

    initial begin
        int pulses, pa, pb, pe, fa, fb, b_at_fa, e_at_fa;
        Reset  = 1'b0;
        keys_n = 3'b000;
        SW     = 8'hA5;
        key_pipe = '{3'b000, 3'b000};
        sw_pipe  = '{8'h00, 8'h00};
        m_run    = '{0, 0, 0};

        // Reset with all keys held, release, full-key release, then a clean LoadA press.
        for (int i = 0; i < 3; i++) add(0, 3'b000, 8'hA5, 3'b000, 3'b000, 8'h00);
        add(1, 3'b000, 8'hA5, 3'b000, 3'b000, 8'h00);
        for (int i = 0; i < 4; i++) add(1, 3'b000, 8'hA5, 3'b000, 3'b000, 8'hA5);
        add(1, 3'b000, 8'hA5, 3'b111, 3'b111, 8'hA5);
        add(1, 3'b000, 8'hA5, 3'b111, 3'b000, 8'hA5);
        add(1, 3'b111, 8'h00, 3'b111, 3'b000, 8'hA5);
        for (int i = 0; i < 4; i++) add(1, 3'b111, 8'h00, 3'b111, 3'b000, 8'h00);
        add(1, 3'b111, 8'h00, 3'b000, 3'b000, 8'h00);
        add(1, 3'b111, 8'h00, 3'b000, 3'b000, 8'h00);
        add(1, 3'b110, 8'h3C, 3'b000, 3'b000, 8'h00);
        for (int i = 0; i < 4; i++) add(1, 3'b110, 8'h3C, 3'b000, 3'b000, 8'h3C);
        add(1, 3'b110, 8'h3C, 3'b001, 3'b001, 8'h3C);
        add(1, 3'b110, 8'h3C, 3'b001, 3'b000, 8'h3C);
        add(1, 3'b110, 8'h3C, 3'b001, 3'b000, 8'h3C);
        for (int i = 0; i < 5; i++) add(1, 3'b111, 8'h3C, 3'b001, 3'b000, 8'h3C);
        add(1, 3'b111, 8'h3C, 3'b000, 3'b000, 8'h3C);

        for (int i = 0; i < vq.size(); i++) begin
            Reset = vq[i].rst; keys_n = vq[i].kn; SW = vq[i].sw;
            tick();
            chk($sformatf("vec%0d_level", i), {5'd0, Execute, LoadB, LoadA}, {5'd0, vq[i].lvl});
            chk($sformatf("vec%0d_pulse", i), {5'd0, Execute_P, LoadB_P, LoadA_P}, {5'd0, vq[i].pls});
            chk($sformatf("vec%0d_din", i), Din, vq[i].din);
        end

        // Bounce: Execute low 3 / high 1, five times, then held low.
        idle(12);
        pulses = 0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) begin
                keys_n = (i < 3) ? 3'b011 : 3'b111;
                tick();
                chk("bounce_exec_low", {7'd0, Execute}, 8'd0);
                pulses += int'(Execute_P);
            end
        end
        keys_n = 3'b011;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("bounce_exec_c%0d", c), {7'd0, Execute}, {7'd0, c >= 6});
            chk($sformatf("bounce_pulse_c%0d", c), {7'd0, Execute_P}, {7'd0, c == 6});
            pulses += int'(Execute_P);
        end
        chk("bounce_pulse_count", 8'(pulses), 8'd1);

        // Simultaneous A/B press, Execute two cycles later, staggered releases.
        idle(12);
        SW = 8'h5A;
        idle(3);
        pa = -1; pb = -1; pe = -1; fa = -1; fb = -1; b_at_fa = 0; e_at_fa = 0;
        for (int t = 0; t < 30; t++) begin
            keys_n[0] = !(t < 14);
            keys_n[1] = !(t < 16);
            keys_n[2] = !(t >= 2 && t < 20);
            tick();
            chk("sim_din_stable", Din, 8'h5A);
            if (LoadA_P && pa < 0) pa = t;
            if (LoadB_P && pb < 0) pb = t;
            if (Execute_P && pe < 0) pe = t;
            if (pa >= 0 && !LoadA && fa < 0) begin
                fa = t; b_at_fa = int'(LoadB); e_at_fa = int'(Execute);
            end
            if (pb >= 0 && !LoadB && fb < 0) fb = t;
        end
        chk("sim_pa", 8'(pa), 8'd5);
        chk("sim_pb_eq_pa", 8'(pb), 8'(pa));
        chk("sim_pe", 8'(pe), 8'(pa + 2));
        chk("sim_fa", 8'(fa), 8'd19);
        chk("sim_fb", 8'(fb), 8'(fa + 2));
        chk("sim_b_held_at_fa", 8'(b_at_fa), 8'd1);
        chk("sim_e_held_at_fa", 8'(e_at_fa), 8'd1);

        // Reset on the third counting edge of a LoadB press, key still held.
        idle(12);
        keys_n = 3'b101;
        for (int t = 1; t <= 13; t++) begin
            Reset = (t != 5);
            tick();
            chk($sformatf("rstmid_level_t%0d", t), {7'd0, LoadB}, {7'd0, t >= 11});
            chk($sformatf("rstmid_pulse_t%0d", t), {7'd0, LoadB_P}, {7'd0, t == 11});
        end

        // Randomized traffic against the reference model.
        idle(12);
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < 3; c++)
                if ($urandom_range(0, 4) == 0) keys_n[c] = ~keys_n[c];
            if ($urandom_range(0, 7) == 0) SW = 8'($urandom_range(0, 255));
            Reset = ($urandom_range(0, 79) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Front-end stage of the 8-bit shift-register lab datapath that sits directly upstream of the shift/load control FSM. It takes the raw push-button KEY inputs and the slide-switch bus, which are bouncy, asynchronous and active-low for KEYs. It synchronizes them to Clk, debounces the three command keys, and delivers clean active-high LoadA, LoadB and Execute levels plus one-cycle press pulses. It also delivers a synchronized 8-bit data bus for the register unit.

## Interface
- DB_CYCLES, default 500000: consecutive stable cycles required before a debounced key output changes; 10 ms at 50 MHz; legal range 1..2^CNT_W-1.
- CNT_W, default 19: debounce counter width per channel.
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-low reset (0 = reset), sampled on posedge Clk.
- LoadA_n  in  1  raw KEY, active-low, asynchronous, may bounce.
- LoadB_n  in  1  raw KEY, active-low, asynchronous, may bounce.
- Execute_n  in  1  raw KEY, active-low, asynchronous, may bounce.
- SW  in  8  raw slide switches, asynchronous.
- LoadA  out  1  debounced level, 1 while KEY held.
- LoadB  out  1  debounced level, 1 while KEY held.
- Execute  out  1  debounced level, 1 while KEY held; the control FSM uses it both to start and to wait for release.
- LoadA_P  out  1  one-cycle pulse on debounced press.
- LoadB_P  out  1  one-cycle pulse on debounced press.
- Execute_P  out  1  one-cycle pulse on debounced press.
- Din  out  8  SW after 2-flop synchronizer.

## Operation
- Each key channel is identical and independent: 2-flop synchronizer s1->s2 on the inverted raw input (s = pressed), a debounced state bit `st`, a counter `cnt[CNT_W-1:0]`, and a registered pulse.
- Channel per-edge rule:
  - If s2 == st: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: st <= s2, cnt <= 0, pulse <= s2 (pulse only on a 0->1 flip).
  - Else: cnt <= cnt+1.
  - The pulse is 0 on every edge where it is not set.
- Any return of s2 to st before the count completes clears cnt. Bounces shorter than DB_CYCLES cycles never reach the outputs.
- Release is debounced with the same rule. No pulse is produced on release.
- Level output = st; pulse output = pulse register. Both are registered, with no combinational path from inputs to outputs.
- SW passes through its own 2-flop synchronizer only, with no debounce. Din = second stage.
- Channels never interact. Simultaneous presses on several keys are debounced and reported independently, in the same cycle if their inputs are identical.

## Timing
- Reset (Reset=0 at an edge) forces the following values:
  - Key synchronizer flops: 0 (not pressed).
  - st: 0.
  - cnt: 0.
  - Pulses: 0.
  - SW synchronizer flops and Din: 0.
- All outputs are 0 in the cycle after any reset edge.
- Reset mid-count aborts the count. If a key is still held when Reset returns to 1, a full debounce interval restarts and a fresh press pulse is produced when it completes.
- Press latency:
  - Raw key first sampled low at edge k.
  - s2 is pressed after edge k+1.
  - The flip occurs at edge k+1+DB_CYCLES.
  - LoadX and LoadX_P are high after that edge. Total latency: DB_CYCLES+2 edges.
- Release latency: same DB_CYCLES+2 edges to the level falling.
- A pulse is high for exactly one cycle, coinciding with the first cycle of the level being high.
- Din latency: 2 edges from SW sampling.
- cnt never exceeds DB_CYCLES-1, so the counter never wraps.
- DB_CYCLES=1: the output flips on the first mismatching edge, giving a 3-edge latency.

## Test plan
All scenarios use DB_CYCLES=4.
- Reset check: hold Reset=0 for 3 cycles with all keys pressed and SW=8'hA5. Required: all outputs 0 throughout. After release with keys held, LoadA/LoadB/Execute rise exactly 6 edges later, each with a single-cycle _P pulse.
- Clean press: LoadA_n goes 1->0 at edge 10 and is held for 20 cycles. Required: LoadA=1 and LoadA_P=1 after edge 15; LoadA_P=0 after edge 16. Release at edge 30: LoadA falls after edge 35; no pulse.
- Bounce rejection: Execute_n toggles low 3 cycles / high 1 cycle, repeated 5 times, then stays low. Required: Execute stays 0 during the bounce. Execute rises exactly 6 edges after the final falling sample, with exactly one Execute_P pulse.
- Simultaneous/independent keys: LoadA_n and LoadB_n are pressed on the same edge, and Execute_n 2 cycles later. Required: LoadA_P and LoadB_P are in the same cycle; Execute_P follows 2 cycles after them; the levels are independent on staggered releases.
- Reset mid-count: press LoadB_n and assert Reset=0 at the 3rd counting edge for 1 cycle, key still held. Required: LoadB=0; LoadB rises 6 edges after Reset returns to 1.
- Switch sync: SW changes 8'h00->8'h3C at edge 20. Required: Din=8'h3C after edge 21, and Din is unchanged by any key activity.
